// File: rtl/br_fifo_ext_arb_burst_rr.sv
// Per-read-port round-robin arbiter with burst hold for the shared multi-FIFO.
// Optional starvation detector enabled by BR_FIFO_EXT_ARB_STARVE_DETECT_EN.
module br_fifo_ext_arb_burst_rr #(
  parameter int unsigned NumReadPorts = 1,
  parameter int unsigned NumFifos     = 2,
  parameter int unsigned BurstLen     = 1,
  parameter int unsigned MaxWait      = 64
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NumReadPorts-1:0][NumFifos-1:0]  arb_request,
  output logic [NumReadPorts-1:0][NumFifos-1:0]  arb_grant,
  input  logic [NumReadPorts-1:0]                arb_enable_priority_update,
  output logic [NumReadPorts-1:0]                starve_err
);

  localparam int unsigned PW  = $clog2(NumFifos);
  localparam int unsigned PW1 = PW + 1;
  localparam int unsigned CW  = $clog2(BurstLen + 1);

  localparam logic [PW:0]   NF   = PW1'(NumFifos);
  localparam logic [PW-1:0] LAST = PW'(NumFifos - 1);
  localparam logic [CW-1:0] BL   = CW'(BurstLen);

  if (NumReadPorts < 1) begin : g_err_nrp
    $error("NumReadPorts must be >= 1");
  end
  if (NumFifos < 2) begin : g_err_nf
    $error("NumFifos must be >= 2");
  end
  if (BurstLen < 1) begin : g_err_bl
    $error("BurstLen must be >= 1");
  end
  if (MaxWait < 2) begin : g_err_mw
    $error("MaxWait must be >= 2");
  end

  for (genvar r = 0; r < NumReadPorts; r++) begin : g_port
    logic [PW-1:0]       ptr;
    logic [CW-1:0]       cnt;
    logic [PW-1:0]       gidx;
    logic                any;
    logic [NumFifos-1:0] gnt;
    logic [PW:0]         sum;
    logic [CW-1:0]       base;
    logic [CW-1:0]       nxt;

    // Rotating priority scan starting at ptr; wrap is explicit so
    // non-power-of-2 NumFifos never indexes past the last requester.
    always_comb begin
      gidx = '0;
      any  = 1'b0;
      sum  = '0;
      for (int unsigned k = 0; k < NumFifos; k++) begin
        sum = {1'b0, ptr} + PW1'(k);
        if (sum >= NF) sum = sum - NF;
        if (!any && arb_request[r][sum[PW-1:0]]) begin
          any  = 1'b1;
          gidx = sum[PW-1:0];
        end
      end
    end

    always_comb begin
      gnt = '0;
      if (any && rst_n) gnt[gidx] = 1'b1;
    end

    assign arb_grant[r] = gnt;

    always_comb begin
      base = (gidx == ptr) ? cnt : '0;
      nxt  = base + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ptr <= '0;
        cnt <= '0;
      end else if (arb_enable_priority_update[r] && any) begin
        if (nxt == BL) begin
          ptr <= (gidx == LAST) ? '0 : gidx + PW'(1);
          cnt <= '0;
        end else begin
          ptr <= gidx;
          cnt <= nxt;
        end
      end
    end

`ifdef BR_FIFO_EXT_ARB_STARVE_DETECT_EN
    localparam int unsigned WW = $clog2(MaxWait + 1);
    localparam logic [WW-1:0] MW = WW'(MaxWait);

    logic [NumFifos-1:0][WW-1:0] wait_cnt;
    logic                        hit;
    logic                        err;

    always_comb begin
      hit = 1'b0;
      for (int unsigned f = 0; f < NumFifos; f++) begin
        if (wait_cnt[f] == MW) hit = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wait_cnt <= '0;
        err      <= 1'b0;
      end else begin
        for (int unsigned f = 0; f < NumFifos; f++) begin
          if (arb_request[r][f] && !gnt[f]) begin
            if (wait_cnt[f] != MW) wait_cnt[f] <= wait_cnt[f] + WW'(1);
          end else begin
            wait_cnt[f] <= '0;
          end
        end
        if (hit) err <= 1'b1;
      end
    end

    assign starve_err[r] = err;
`else
    assign starve_err[r] = 1'b0;
`endif
  end

endmodule
